// File: rtl/register_bank_param.sv
// ----------------------------------------------------------------------------
// register_bank_param
//
// Parametrised multi-entry register bank placed between the datapath/ALU and
// the operand fetch stage. One clocked write port, two independent registered
// read ports (A/B) and a sequenced bulk-clear engine that zeroes one entry per
// cycle while busy_o... (busy) is high.
//
// Parameters:
//   WIDTH      data width of each register
//   DEPTH      number of registers (2..2**ADDR_W)
//   ADDR_W     address width
//   ZERO_REG0  1: register 0 always reads 0 and ignores writes
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   we/waddr/wdata   write port (dropped while busy, out of range, or reg 0
//                    when ZERO_REG0=1)
//   re_a/raddr_a     read port A request, rdata_a registered result
//   re_b/raddr_b     read port B request, rdata_b registered result
//   clr_req          single-cycle request to zero all registers
//   busy             high while the clear sequence runs
//
// Build option:
//   REGBANK_BYPASS_EN  when defined, a read whose address matches a legal
//                      write on the same edge returns the write data instead
//                      of the old contents.
// ----------------------------------------------------------------------------
module register_bank_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 5,
    parameter bit ZERO_REG0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              clr_req,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // One extra bit so DEPTH == 2**ADDR_W is representable in the range test.
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0]  rdata_b_q, rdata_b_d;
    logic              clearing;
    logic              write_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_X);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG0 && (a == '0));
    endfunction

    // Clear FSM state and sweep counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Requests arriving while already clearing are ignored; the sweep ends
    // after zeroing entry DEPTH-1 so the counter never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        clearing = (state_q == CLEAR);
        busy     = clearing;
    end

    assign write_ok = we && !clearing && in_range(waddr) && !is_zero_reg(waddr);

    // Storage. A legal write and a clear step are mutually exclusive since
    // writes are only accepted while idle; a write on the clr_req edge lands
    // first and is then swept by the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (write_ok) begin
                mem_q[waddr] <= wdata;
            end
            if (clearing) begin
                mem_q[cnt_q] <= '0;
            end
        end
    end

    // Read ports hold their last value when not enabled.
    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (re_a) begin
            if (!in_range(raddr_a) || is_zero_reg(raddr_a)) begin
                rdata_a_d = '0;
            end else begin
                rdata_a_d = mem_q[raddr_a];
            end
`ifdef REGBANK_BYPASS_EN
            if (write_ok && (waddr == raddr_a)) begin
                rdata_a_d = wdata;
            end
`endif
        end
        if (re_b) begin
            if (!in_range(raddr_b) || is_zero_reg(raddr_b)) begin
                rdata_b_d = '0;
            end else begin
                rdata_b_d = mem_q[raddr_b];
            end
`ifdef REGBANK_BYPASS_EN
            if (write_ok && (waddr == raddr_b)) begin
                rdata_b_d = wdata;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: tb/tb_register_bank_param.sv
// ----------------------------------------------------------------------------
// tb_register_bank_param
//
// Drives two bank instances from shared inputs: bank 0 with default
// parameters and bank 1 with DEPTH=24, ZERO_REG0=1. A behavioural model keeps
// the expected contents of both banks as plain arrays and a remaining-clear
// cycle count, and every cycle's outputs are compared against it.
// ----------------------------------------------------------------------------
module tb_register_bank_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        re_a = 1'b0;
    logic [4:0]  raddr_a = '0;
    logic        re_b = 1'b0;
    logic [4:0]  raddr_b = '0;
    logic        clr_req = 1'b0;

    logic [31:0] rdA0, rdB0, rdA1, rdB1;
    logic        busy0, busy1;

    int checks = 0;
    int errors = 0;

`ifdef REGBANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    register_bank_param #(
        .WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG0(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdA0),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdB0),
        .clr_req(clr_req), .busy(busy0)
    );

    register_bank_param #(
        .WIDTH(32), .DEPTH(24), .ADDR_W(5), .ZERO_REG0(1'b1)
    ) dut24 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdA1),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdB1),
        .clr_req(clr_req), .busy(busy1)
    );

    // Behavioural model: contents, remaining clear cycles and expected reads.
    logic [31:0] m [2][32];
    int          dep [2];
    bit          z0 [2];
    int          rem [2];
    logic [31:0] expA [2];
    logic [31:0] expB [2];

    task automatic modelReset();
        dep[0] = 32; z0[0] = 1'b0;
        dep[1] = 24; z0[1] = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 32; i++) m[b][i] = '0;
            rem[b]  = 0;
            expA[b] = '0;
            expB[b] = '0;
        end
    endtask

    function automatic logic [31:0] modelRead(input int b, input int a);
        if (a >= dep[b] || (z0[b] && a == 0)) return '0;
        return m[b][a];
    endfunction

    // Applies the inputs present at a rising edge to the model.
    task automatic modelEdge();
        for (int b = 0; b < 2; b++) begin
            bit legal;
            legal = (rem[b] == 0) && we && (int'(waddr) < dep[b]) &&
                    !(z0[b] && waddr == 5'd0);
            if (re_a) begin
                expA[b] = modelRead(b, int'(raddr_a));
                if (BYP && legal && waddr == raddr_a) expA[b] = wdata;
            end
            if (re_b) begin
                expB[b] = modelRead(b, int'(raddr_b));
                if (BYP && legal && waddr == raddr_b) expB[b] = wdata;
            end
            if (rem[b] > 0) begin
                m[b][dep[b] - rem[b]] = '0;
                rem[b]--;
            end else begin
                if (legal) m[b][waddr] = wdata;
                if (clr_req) rem[b] = dep[b];
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " rdata_a bank0"}, rdA0, expA[0]);
        checkOutput({tag, " rdata_b bank0"}, rdB0, expB[0]);
        checkOutput({tag, " busy bank0"}, {31'b0, busy0}, {31'b0, rem[0] > 0});
        checkOutput({tag, " rdata_a bank1"}, rdA1, expA[1]);
        checkOutput({tag, " rdata_b bank1"}, rdB1, expB[1]);
        checkOutput({tag, " busy bank1"}, {31'b0, busy1}, {31'b0, rem[1] > 0});
    endtask

    // Drives one cycle of inputs, clocks it, then compares at the falling edge.
    task automatic applyStimulus(input logic w, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic ra,
                                 input logic [4:0] aa, input logic rb,
                                 input logic [4:0] ab, input logic c,
                                 input string tag);
        we = w; waddr = wa; wdata = wd;
        re_a = ra; raddr_a = aa; re_b = rb; raddr_b = ab; clr_req = c;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkModel(tag);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        reA;
        logic [4:0]  raA;
        logic        reB;
        logic [4:0]  raB;
        logic [31:0] expA;
        logic [31:0] expB;
    } vec_t;

    vec_t vecs [9];

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyCount0;
        int busyCount1;

        // Expected outputs refer to bank 0 (DEPTH=32, reg 0 writable).
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0};
        vecs[4] = '{1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b1, 5'd7,
                    32'hDEADBEEF, BYP ? 32'h12345678 : 32'h1};
        vecs[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd7,
                    32'hDEADBEEF, 32'h12345678};
        vecs[6] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b1, 5'd5, 32'h0, 32'hDEADBEEF};
        vecs[7] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0,
                    BYP ? 32'hFFFFFFFF : 32'h0, 32'hDEADBEEF};
        vecs[8] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0,
                    32'hFFFFFFFF, 32'hDEADBEEF};

        // Asynchronous reset with no clock edge in between.
        modelReset();
        #1 rst_n = 1'b0;
        #1;
        checkModel("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int a = 0; a < 32; a++)
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 5'(31 - a), 1'b0,
                          "read after reset");

        // Directed write/read/hold/same-edge vectors.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].reA,
                          vecs[i].raA, vecs[i].reB, vecs[i].raB, 1'b0,
                          $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d table rdata_a", i), rdA0, vecs[i].expA);
            checkOutput($sformatf("vec%0d table rdata_b", i), rdB0, vecs[i].expB);
        end

        // Bank 1: reg 0 and address 24 are not writable and read 0.
        applyStimulus(1'b1, 5'd24, 32'h77777777, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                      "write oob");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd24, 1'b0, "read zero/oob");
        checkOutput("bank1 reg0 reads zero", rdA1, 32'h0);
        checkOutput("bank1 addr24 reads zero", rdB1, 32'h0);

        // Fill, then bulk clear with writes and a second request during busy.
        for (int a = 0; a < 32; a++)
            applyStimulus(1'b1, 5'(a), 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, "fill");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, "clr pulse");
        busyCount0 = busy0 ? 1 : 0;
        busyCount1 = busy1 ? 1 : 0;
        for (int k = 0; k < 60; k++) begin
            applyStimulus(1'b1, 5'($urandom_range(0, 31)), $urandom, 1'b1,
                          5'($urandom_range(0, 31)), 1'b0, 5'd0, 1'b0 | (k == 5),
                          "during clear");
            if (busy0) busyCount0++;
            if (busy1) busyCount1++;
            if (!busy0 && !busy1) break;
        end
        checkOutput("busy length bank0", 32'(busyCount0), 32'd32);
        checkOutput("busy length bank1", 32'(busyCount1), 32'd24);
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b0, 5'd0, 1'b0, "after clear");
            checkOutput($sformatf("bank0 reg%0d cleared", a), rdA0, 32'h0);
        end

        // Write on the same edge as the clear request ends up zero.
        applyStimulus(1'b1, 5'd4, 32'h44444444, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, "wr+clr");
        for (int k = 0; k < 32; k++)
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, "wr+clr run");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, "wr+clr read");
        checkOutput("wr+clr entry zero", rdA0, 32'h0);

        // Randomised traffic.
        for (int k = 0; k < 400; k++)
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 49) == 0), "random");
        for (int k = 0; k < 40; k++)
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, "drain");

        // Reset asserted in the middle of a clear sequence.
        applyStimulus(1'b1, 5'd20, 32'h55AA55AA, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, "pre");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, "clr for reset");
        for (int k = 0; k < 10; k++)
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 1'b1, 5'd20, 1'b0, "clr pre-reset");
        checkOutput("pre-reset busy", {31'b0, busy0}, 32'h1);
        checkOutput("pre-reset rdata_a", rdA0, 32'h55AA55AA);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid-clear reset rdata_a", rdA0, 32'h0);
        checkOutput("mid-clear reset rdata_b", rdB1, 32'h0);
        checkOutput("mid-clear reset busy0", {31'b0, busy0}, 32'h0);
        checkOutput("mid-clear reset busy1", {31'b0, busy1}, 32'h0);
        modelReset();
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, "post wr");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd20, 1'b0, "post rd");
        checkOutput("post-reset write", rdA0, 32'hCAFEF00D);
        checkOutput("post-reset old entry", rdB0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
